// File: rtl/mem_access_stage.sv
// MEM pipeline stage: aligns stores, extracts loads, runs the req/ack handshake
// with data memory (with timeout) and registers the MEM_WB writeback result.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        dbg,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_regwrite,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic [4:0]  EX_MEM_loadcntrl,
  input  logic [2:0]  EX_MEM_storecntrl,
  input  logic [31:0] EX_MEM_alures,
  input  logic [31:0] EX_MEM_mulres,
  input  logic [31:0] EX_MEM_divres,
  input  logic        EX_MEM_mul_ready,
  input  logic        EX_MEM_div_ready,
  input  logic [31:0] EX_MEM_dout_rs2,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_hold,
  output logic [4:0]  MEM_WB_rd,
  output logic        MEM_WB_regwrite,
  output logic [31:0] WB_res,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  cnt_reg;

  logic        is_load, is_store, mem_op, misaligned, aligned_op;
  logic        in_wait, timeout_fire, wb_we;
  logic [1:0]  addr_lo;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data, wb_data;

  // A load wins when both read and write are (illegally) raised.
  assign is_load  = EX_MEM_memread;
  assign is_store = EX_MEM_memwrite & ~EX_MEM_memread;
  assign mem_op   = is_load | is_store;
  assign addr_lo  = EX_MEM_alures[1:0];

  assign misaligned =
      (is_load  & (((EX_MEM_loadcntrl[1] | EX_MEM_loadcntrl[4]) & addr_lo[0]) |
                   (EX_MEM_loadcntrl[2] & (addr_lo != 2'b00)))) |
      (is_store & ((EX_MEM_storecntrl[1] & addr_lo[0]) |
                   (EX_MEM_storecntrl[2] & (addr_lo != 2'b00))));
  assign aligned_op = mem_op & ~misaligned;

  assign in_wait      = (state_reg == WAIT);
  assign timeout_fire = in_wait & (cnt_reg == CNT_LAST) & ~mem_ack;
  assign mem_req      = Rst & (in_wait | aligned_op);
  assign mem_hold     = mem_req & ~mem_ack & ~timeout_fire;

  assign mem_we   = is_store;
  assign mem_addr = {EX_MEM_alures[31:2], 2'b00};

  always_comb begin
    mem_be    = 4'hF;
    mem_wdata = EX_MEM_dout_rs2;
    if (is_store && EX_MEM_storecntrl[0]) begin
      mem_be    = 4'b0001 << addr_lo;
      mem_wdata = {4{EX_MEM_dout_rs2[7:0]}};
    end else if (is_store && EX_MEM_storecntrl[1]) begin
      mem_be    = 4'b0011 << addr_lo;
      mem_wdata = {2{EX_MEM_dout_rs2[15:0]}};
    end
  end

  always_comb begin
    case (addr_lo)
      2'd0:    load_byte = mem_rdata[7:0];
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = 32'h0;
    if (EX_MEM_loadcntrl[0])      load_data = {{24{load_byte[7]}}, load_byte};
    else if (EX_MEM_loadcntrl[3]) load_data = {24'h0, load_byte};
    else if (EX_MEM_loadcntrl[1]) load_data = {{16{load_half[15]}}, load_half};
    else if (EX_MEM_loadcntrl[4]) load_data = {16'h0, load_half};
    else if (EX_MEM_loadcntrl[2]) load_data = mem_rdata;
  end

  always_comb begin
    if (is_load)               wb_data = load_data;
    else if (is_store)         wb_data = EX_MEM_alures;
    else if (EX_MEM_mul_ready) wb_data = EX_MEM_mulres;
    else if (EX_MEM_div_ready) wb_data = EX_MEM_divres;
    else                       wb_data = EX_MEM_alures;
  end

  // Aborted or faulting accesses and stores retire without a register write.
  assign wb_we = EX_MEM_regwrite & ~is_store & ~misaligned & ~timeout_fire;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= 8'd0;
      MEM_WB_rd       <= 5'd0;
      MEM_WB_regwrite <= 1'b0;
      WB_res          <= 32'h0;
      misalign        <= 1'b0;
      bus_err         <= 1'b0;
    end else if (!dbg) begin
      case (state_reg)
        IDLE: begin
          if (aligned_op && !mem_ack) begin
            state_reg <= WAIT;
            cnt_reg   <= 8'd1;
          end
        end
        default: begin
          if (mem_ack || timeout_fire) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
      endcase

      if (mem_hold) begin
        MEM_WB_regwrite <= 1'b0;
      end else begin
        MEM_WB_rd       <= EX_MEM_rd;
        MEM_WB_regwrite <= wb_we;
        WB_res          <= wb_data;
      end

      if (misaligned)   misalign <= 1'b1;
      if (timeout_fire) bus_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// random instructions, all checked against a behavioural instruction model.
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic        dbg = 1'b0;
  logic [4:0]  EX_MEM_rd = '0;
  logic        EX_MEM_regwrite = 1'b0;
  logic        EX_MEM_memread = 1'b0;
  logic        EX_MEM_memwrite = 1'b0;
  logic [4:0]  EX_MEM_loadcntrl = '0;
  logic [2:0]  EX_MEM_storecntrl = '0;
  logic [31:0] EX_MEM_alures = '0;
  logic [31:0] EX_MEM_mulres = '0;
  logic [31:0] EX_MEM_divres = '0;
  logic        EX_MEM_mul_ready = 1'b0;
  logic        EX_MEM_div_ready = 1'b0;
  logic [31:0] EX_MEM_dout_rs2 = '0;
  logic        mem_req, mem_we, mem_hold;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_regwrite;
  logic [31:0] WB_res;
  logic        misalign, bus_err;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .Rst(Rst), .dbg(dbg),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_regwrite(EX_MEM_regwrite),
    .EX_MEM_memread(EX_MEM_memread), .EX_MEM_memwrite(EX_MEM_memwrite),
    .EX_MEM_loadcntrl(EX_MEM_loadcntrl), .EX_MEM_storecntrl(EX_MEM_storecntrl),
    .EX_MEM_alures(EX_MEM_alures), .EX_MEM_mulres(EX_MEM_mulres),
    .EX_MEM_divres(EX_MEM_divres), .EX_MEM_mul_ready(EX_MEM_mul_ready),
    .EX_MEM_div_ready(EX_MEM_div_ready), .EX_MEM_dout_rs2(EX_MEM_dout_rs2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_hold(mem_hold),
    .MEM_WB_rd(MEM_WB_rd), .MEM_WB_regwrite(MEM_WB_regwrite),
    .WB_res(WB_res), .misalign(misalign), .bus_err(bus_err)
  );

  typedef struct {
    logic        rd_op, wr_op;
    logic [4:0]  lc;
    logic [2:0]  sc;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu, mul, div, rs2, rdata;
    logic        mul_rdy, div_rdy;
  } op_t;

  int errors = 0;
  int checks = 0;

  // Architectural state the stage should expose after each retirement.
  logic [4:0]  exp_rd = '0;
  logic        exp_rw = 1'b0;
  logic [31:0] exp_wb = '0;
  logic        exp_mis = 1'b0;
  logic        exp_berr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic op_t blank_op();
    op_t o;
    o.rd_op = 0; o.wr_op = 0; o.lc = '0; o.sc = '0; o.rd = '0; o.rw = 0;
    o.alu = '0; o.mul = '0; o.div = '0; o.rs2 = '0; o.rdata = '0;
    o.mul_rdy = 0; o.div_rdy = 0;
    return o;
  endfunction

  // Access width in bytes of a load/store.
  function automatic int acc_size(op_t o);
    if (o.rd_op) return (o.lc[0] | o.lc[3]) ? 1 : (o.lc[1] | o.lc[4]) ? 2 : 4;
    return o.sc[0] ? 1 : o.sc[1] ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_value(op_t o);
    int          sz;
    int          ofs;
    logic [63:0] v;
    logic [63:0] mask;
    sz   = acc_size(o);
    ofs  = int'(o.alu % 4);
    mask = (64'd1 << (8 * sz)) - 64'd1;
    v    = ({32'h0, o.rdata} >> (8 * ofs)) & mask;
    if ((o.lc[0] | o.lc[1]) && v[8 * sz - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic apply(op_t o);
    EX_MEM_rd = o.rd; EX_MEM_regwrite = o.rw;
    EX_MEM_memread = o.rd_op; EX_MEM_memwrite = o.wr_op;
    EX_MEM_loadcntrl = o.lc; EX_MEM_storecntrl = o.sc;
    EX_MEM_alures = o.alu; EX_MEM_mulres = o.mul; EX_MEM_divres = o.div;
    EX_MEM_mul_ready = o.mul_rdy; EX_MEM_div_ready = o.div_rdy;
    EX_MEM_dout_rs2 = o.rs2; mem_rdata = o.rdata;
  endtask

  // Runs one instruction; delay = cycles until ack (0 = same cycle, <0 = never).
  task automatic do_op(input string name, input op_t o, input int delay);
    bit          is_mem, is_load, is_store, mis, aligned, tmo;
    int          sz, ofs, exp_hold, cyc, holds;
    logic [3:0]  be_exp;
    logic [31:0] wd_exp;
    is_load  = o.rd_op;
    is_store = o.wr_op && !o.rd_op;
    is_mem   = is_load || is_store;
    sz       = acc_size(o);
    ofs      = int'(o.alu % 4);
    mis      = is_mem && (int'(o.alu % sz) != 0);
    aligned  = is_mem && !mis;
    tmo      = aligned && (delay < 0 || delay > TIMEOUT - 1);
    exp_hold = !aligned ? 0 : (tmo ? TIMEOUT - 1 : delay);
    be_exp   = is_load ? 4'hF : 4'(((1 << sz) - 1) << ofs);
    wd_exp   = (sz == 1) ? o.rs2[7:0] * 32'h01010101 :
               (sz == 2) ? o.rs2[15:0] * 32'h00010001 : o.rs2;
    holds    = 0;
    apply(o);
    for (cyc = 0; cyc <= TIMEOUT; cyc++) begin
      mem_ack = aligned && (cyc == delay);
      @(negedge clk);
      check({name, ".mem_req"}, mem_req, aligned);
      check({name, ".mem_hold"}, mem_hold, cyc < exp_hold);
      if (mem_hold) holds++;
      if (aligned) begin
        check({name, ".mem_addr"}, mem_addr, o.alu & 32'hFFFF_FFFC);
        check({name, ".mem_we"}, mem_we, is_store);
        check({name, ".mem_be"}, mem_be, be_exp);
        if (is_store) check({name, ".mem_wdata"}, mem_wdata, wd_exp);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (cyc >= exp_hold) break;
      check({name, ".bubble_rw"}, MEM_WB_regwrite, 1'b0);
      check({name, ".bubble_rd"}, MEM_WB_rd, exp_rd);
    end
    exp_rd   = o.rd;
    exp_rw   = o.rw && !is_store && !mis && !tmo;
    exp_wb   = is_load ? load_value(o) : is_store ? o.alu :
               o.mul_rdy ? o.mul : o.div_rdy ? o.div : o.alu;
    exp_mis  = exp_mis | mis;
    exp_berr = exp_berr | tmo;
    check({name, ".hold_cycles"}, holds, exp_hold);
    check({name, ".MEM_WB_rd"}, MEM_WB_rd, exp_rd);
    check({name, ".MEM_WB_regwrite"}, MEM_WB_regwrite, exp_rw);
    if (!(is_load && (mis || tmo))) check({name, ".WB_res"}, WB_res, exp_wb);
    check({name, ".misalign"}, misalign, exp_mis);
    check({name, ".bus_err"}, bus_err, exp_berr);
    $display("%s: addr=%h rd=%0d hold=%0d wb=%h rw=%0b mis=%0b berr=%0b",
             name, o.alu, o.rd, holds, WB_res, MEM_WB_regwrite, misalign, bus_err);
  endtask

  initial begin
    op_t o;
    int  r, delay;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset.mem_req", mem_req, 1'b0);
    check("reset.MEM_WB_rd", MEM_WB_rd, 5'd0);
    check("reset.MEM_WB_regwrite", MEM_WB_regwrite, 1'b0);
    check("reset.WB_res", WB_res, 32'h0);
    check("reset.misalign", misalign, 1'b0);
    check("reset.bus_err", bus_err, 1'b0);
    Rst = 1'b1;
    @(posedge clk); #1;

    // Zero-wait lw.
    o = blank_op(); o.rd_op = 1; o.lc = 5'b00100; o.rd = 5; o.rw = 1;
    o.alu = 32'h100; o.rdata = 32'hDEADBEEF;
    do_op("lw_zero_wait", o, 0);

    // lb / lbu with three wait cycles.
    o = blank_op(); o.rd_op = 1; o.lc = 5'b00001; o.rd = 6; o.rw = 1;
    o.alu = 32'h103; o.rdata = 32'h80FF_1234;
    do_op("lb_wait3", o, 3);
    o.lc = 5'b01000;
    do_op("lbu_wait3", o, 3);

    // sh to upper half.
    o = blank_op(); o.wr_op = 1; o.sc = 3'b010; o.rd = 7; o.rw = 0;
    o.alu = 32'h202; o.rs2 = 32'h0000ABCD;
    do_op("sh_upper", o, 1);

    // Misaligned sw, then a plain ALU op.
    o = blank_op(); o.wr_op = 1; o.sc = 3'b100; o.alu = 32'h301; o.rs2 = 32'h1;
    do_op("sw_misaligned", o, 0);
    o = blank_op(); o.rd = 3; o.rw = 1; o.alu = 32'd7;
    do_op("alu_after_mis", o, 0);

    // Timeout: no ack ever.
    o = blank_op(); o.rd_op = 1; o.lc = 5'b00100; o.rd = 8; o.rw = 1;
    o.alu = 32'h400; o.rdata = 32'h55AA55AA;
    do_op("lw_timeout", o, -1);

    // Reset asserted mid-WAIT.
    o = blank_op(); o.rd_op = 1; o.lc = 5'b00100; o.rd = 4; o.rw = 1; o.alu = 32'h40;
    apply(o);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wait.hold_before", mem_hold, 1'b1);
    #2 Rst = 1'b0;
    #1;
    check("rst_wait.mem_req", mem_req, 1'b0);
    check("rst_wait.MEM_WB_rd", MEM_WB_rd, 5'd0);
    check("rst_wait.MEM_WB_regwrite", MEM_WB_regwrite, 1'b0);
    check("rst_wait.WB_res", WB_res, 32'h0);
    check("rst_wait.misalign", misalign, 1'b0);
    check("rst_wait.bus_err", bus_err, 1'b0);
    exp_rd = '0; exp_rw = 0; exp_wb = '0; exp_mis = 0; exp_berr = 0;
    apply(blank_op());
    @(negedge clk); Rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wait.after_release_rw", MEM_WB_regwrite, 1'b0);

    // mul_ready select, held off by two cycles of dbg.
    o = blank_op(); o.rd = 9; o.rw = 1; o.alu = 32'h34; o.mul = 32'h12; o.mul_rdy = 1;
    apply(o);
    dbg = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("dbg.MEM_WB_rd_frozen", MEM_WB_rd, exp_rd);
      check("dbg.WB_res_frozen", WB_res, exp_wb);
    end
    dbg = 1'b0;
    do_op("mul_after_dbg", o, 0);

    // Random instruction stream.
    for (int n = 0; n < 80; n++) begin
      o = blank_op();
      o.rd = 5'($urandom); o.rw = 1'($urandom);
      o.alu = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 3));
      o.mul = $urandom; o.div = $urandom; o.rs2 = $urandom; o.rdata = $urandom;
      r = $urandom_range(0, 2);
      if (r == 0) begin
        o.mul_rdy = 1'($urandom); o.div_rdy = 1'($urandom);
      end else if (r == 1) begin
        o.rd_op = 1; o.lc = 5'(1 << $urandom_range(0, 4));
      end else begin
        o.wr_op = 1; o.sc = 3'(1 << $urandom_range(0, 2));
      end
      r = $urandom_range(0, 12);
      delay = (r == 12) ? -1 : r % 5;
      do_op($sformatf("rand%0d", n), o, delay);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
